// File: rtl/param_editor.sv
// param_editor: debounced push-button editor holding one parameter store per effect.
// Build macro PARAM_EDITOR_AUTOREPEAT_EN adds auto-repeat of held up/down keys.
module param_editor #(
  parameter int FX_COUNT        = 16,
  parameter int PARAM_COUNT     = 8,
  parameter int PARAM_W         = 7,
  parameter int STEP            = 1,
  parameter int RESET_VAL       = 0,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [3:0]                               KEY,
  input  logic [9:0]                               SW,
  output logic [$clog2(FX_COUNT)-1:0]              fx_sel,
  output logic [$clog2(PARAM_COUNT)-1:0]           param_sel,
  output logic [PARAM_W-1:0]                       current_value,
  output logic [FX_COUNT*PARAM_COUNT*PARAM_W-1:0]  param_flat,
  output logic                                     param_changed
);

  // state  | meaning
  // IDLE   | waiting for a debounced press
  // ACT    | one cycle: apply the latched action
  // HOLD   | waiting for all keys released (auto-repeat timing when enabled)

  localparam int FX_W  = $clog2(FX_COUNT);
  localparam int PS_W  = $clog2(PARAM_COUNT);
  localparam int N_ENT = FX_COUNT * PARAM_COUNT;
  localparam int IDX_W = $clog2(N_ENT);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [PARAM_W:0]   MAX_VAL = {1'b0, {PARAM_W{1'b1}}};
  localparam logic [PARAM_W:0]   STEP_X  = (PARAM_W+1)'(STEP);
  localparam logic [PARAM_W-1:0] RST_V   = PARAM_W'(RESET_VAL);
  localparam logic [DB_W-1:0]    DB_LD   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FX_W-1:0]    FX_LAST = FX_W'(FX_COUNT - 1);
  localparam logic [PS_W-1:0]    PS_LAST = PS_W'(PARAM_COUNT - 1);

`ifdef PARAM_EDITOR_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  // Loaded in ACT so the ACT-to-ACT spacing equals the delay/rate exactly.
  localparam logic [RPT_W-1:0] RPT_DLY_LD = RPT_W'((REPEAT_DELAY > 1) ? REPEAT_DELAY - 2 : 0);
  localparam logic [RPT_W-1:0] RPT_RATE_LD = RPT_W'((REPEAT_RATE > 1) ? REPEAT_RATE - 2 : 0);
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACT, S_HOLD} state_t;
  typedef enum logic [1:0] {A_UP, A_DOWN, A_PARAM, A_FX} action_t;

  state_t  state_q, state_d;
  action_t act_q, act_d;

  logic [3:0]        key_meta_q, key_meta_d;
  logic [3:0]        key_sync_q, key_sync_d;
  logic              lock_meta_q, lock_meta_d;
  logic              lock_q, lock_d;
  logic [3:0]        db_q, db_d;
  logic [3:0]        db_prev_q, db_prev_d;
  logic [DB_W-1:0]   db_cnt_q [4];
  logic [DB_W-1:0]   db_cnt_d [4];

  logic [FX_W-1:0]    fx_sel_q, fx_sel_d;
  logic [PS_W-1:0]    param_sel_q, param_sel_d;
  logic [PARAM_W-1:0] store_q [N_ENT];
  logic [PARAM_W-1:0] store_d [N_ENT];
  logic               param_changed_q, param_changed_d;

`ifdef PARAM_EDITOR_AUTOREPEAT_EN
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_again_q, rpt_again_d;
  logic             held_val;
`endif

  logic [3:0]         key_lvl;
  logic [3:0]         press;
  logic [IDX_W-1:0]   cur_idx;
  logic [PARAM_W-1:0] cur_val;
  logic [PARAM_W:0]   up_sum;
  logic [PARAM_W:0]   up_sat;
  logic [PARAM_W-1:0] up_val;
  logic [PARAM_W-1:0] dn_val;
  logic [PARAM_W-1:0] new_val;
  logic               unused_sw;

  assign unused_sw = ^SW[9:1];

  // Input synchronizers and per-key debounce down-counters.
  always_comb begin
    key_meta_d  = KEY;
    key_sync_d  = key_meta_q;
    lock_meta_d = SW[0];
    lock_d      = lock_meta_q;
    db_prev_d   = db_q;
    key_lvl     = ~key_sync_q;
    press       = db_q & ~db_prev_q;
    db_d        = db_q;
    for (int k = 0; k < 4; k++) begin
      db_cnt_d[k] = DB_LD;
      if (key_lvl[k] != db_q[k]) begin
        if (db_cnt_q[k] == '0) db_d[k] = key_lvl[k];
        else                   db_cnt_d[k] = db_cnt_q[k] - DB_W'(1);
      end
    end
  end

  always_comb begin
    cur_idx = IDX_W'(fx_sel_q) * IDX_W'(PARAM_COUNT) + IDX_W'(param_sel_q);
    cur_val = store_q[cur_idx];
    up_sum  = {1'b0, cur_val} + STEP_X;
    up_sat  = (up_sum > MAX_VAL) ? MAX_VAL : up_sum;
    up_val  = up_sat[PARAM_W-1:0];
    dn_val  = ({1'b0, cur_val} < STEP_X) ? '0 : cur_val - PARAM_W'(STEP);
    new_val = (act_q == A_UP) ? up_val : dn_val;
  end

  always_comb begin
    state_d         = state_q;
    act_d           = act_q;
    fx_sel_d        = fx_sel_q;
    param_sel_d     = param_sel_q;
    store_d         = store_q;
    param_changed_d = 1'b0;
`ifdef PARAM_EDITOR_AUTOREPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_again_d = rpt_again_q;
    held_val    = ((act_q == A_UP) && db_q[0]) || ((act_q == A_DOWN) && db_q[1]);
`endif
    case (state_q)
      S_IDLE: begin
        if (|press) begin
          state_d = S_ACT;
          if      (press[3]) act_d = A_FX;
          else if (press[2]) act_d = A_PARAM;
          else if (press[1]) act_d = A_DOWN;
          else               act_d = A_UP;
`ifdef PARAM_EDITOR_AUTOREPEAT_EN
          rpt_again_d = 1'b0;
`endif
        end
      end
      S_ACT: begin
        state_d = S_HOLD;
        case (act_q)
          A_FX:    fx_sel_d    = (fx_sel_q == FX_LAST) ? '0 : fx_sel_q + FX_W'(1);
          A_PARAM: param_sel_d = (param_sel_q == PS_LAST) ? '0 : param_sel_q + PS_W'(1);
          default: begin
            // Lock suppresses value edits only; navigation is unaffected.
            if (!lock_q) begin
              store_d[cur_idx] = new_val;
              param_changed_d  = (new_val != cur_val);
            end
          end
        endcase
`ifdef PARAM_EDITOR_AUTOREPEAT_EN
        rpt_cnt_d = rpt_again_q ? RPT_RATE_LD : RPT_DLY_LD;
`endif
      end
      S_HOLD: begin
`ifdef PARAM_EDITOR_AUTOREPEAT_EN
        if (~|db_q) begin
          state_d   = S_IDLE;
          rpt_cnt_d = '0;
        end else if (held_val) begin
          if (rpt_cnt_q == '0) begin
            state_d     = S_ACT;
            rpt_again_d = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
          end
        end
`else
        if (~|db_q) state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q      <= 4'hF;
      key_sync_q      <= 4'hF;
      lock_meta_q     <= 1'b0;
      lock_q          <= 1'b0;
      db_q            <= '0;
      db_prev_q       <= '0;
      for (int k = 0; k < 4; k++) db_cnt_q[k] <= DB_LD;
      state_q         <= S_IDLE;
      act_q           <= A_UP;
      fx_sel_q        <= '0;
      param_sel_q     <= '0;
      for (int i = 0; i < N_ENT; i++) store_q[i] <= RST_V;
      param_changed_q <= 1'b0;
`ifdef PARAM_EDITOR_AUTOREPEAT_EN
      rpt_cnt_q       <= '0;
      rpt_again_q     <= 1'b0;
`endif
    end else begin
      key_meta_q      <= key_meta_d;
      key_sync_q      <= key_sync_d;
      lock_meta_q     <= lock_meta_d;
      lock_q          <= lock_d;
      db_q            <= db_d;
      db_prev_q       <= db_prev_d;
      for (int k = 0; k < 4; k++) db_cnt_q[k] <= db_cnt_d[k];
      state_q         <= state_d;
      act_q           <= act_d;
      fx_sel_q        <= fx_sel_d;
      param_sel_q     <= param_sel_d;
      for (int i = 0; i < N_ENT; i++) store_q[i] <= store_d[i];
      param_changed_q <= param_changed_d;
`ifdef PARAM_EDITOR_AUTOREPEAT_EN
      rpt_cnt_q       <= rpt_cnt_d;
      rpt_again_q     <= rpt_again_d;
`endif
    end
  end

  assign fx_sel        = fx_sel_q;
  assign param_sel     = param_sel_q;
  assign current_value = cur_val;
  assign param_changed = param_changed_q;

  for (genvar g = 0; g < N_ENT; g++) begin : g_flat
    assign param_flat[g*PARAM_W +: PARAM_W] = store_q[g];
  end

endmodule

// File: tb/tb_param_editor.sv
// Directed self-checking bench for param_editor (short debounce/repeat timing).
module tb_param_editor;
  localparam int FX_COUNT    = 16;
  localparam int PARAM_COUNT = 8;
  localparam int PARAM_W     = 7;
  localparam int FLAT_W      = FX_COUNT * PARAM_COUNT * PARAM_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        KEY;
  logic [9:0]        SW;
  logic [3:0]        fx_sel;
  logic [2:0]        param_sel;
  logic [6:0]        current_value;
  logic [FLAT_W-1:0] param_flat;
  logic              param_changed;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  param_editor #(
    .FX_COUNT(FX_COUNT), .PARAM_COUNT(PARAM_COUNT), .PARAM_W(PARAM_W), .STEP(1),
    .RESET_VAL(0), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .KEY(KEY), .SW(SW),
    .fx_sel(fx_sel), .param_sel(param_sel), .current_value(current_value),
    .param_flat(param_flat), .param_changed(param_changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (param_changed === 1'b1) pulse_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic press_key(input int k, input int hold_cyc, input int rel_cyc);
    @(negedge clk);
    KEY[k] = 1'b0;
    repeat (hold_cyc) @(negedge clk);
    KEY[k] = 1'b1;
    repeat (rel_cyc) @(negedge clk);
  endtask

  task automatic test_reset;
    KEY = 4'hF; SW = '0; rst_n = 1'b0;
    #1;
    n_vec++; if (fx_sel !== 4'd0) begin n_err++; $display("FAIL reset_fx: got %0d want 0", fx_sel); end
    n_vec++; if (param_sel !== 3'd0) begin n_err++; $display("FAIL reset_param: got %0d want 0", param_sel); end
    n_vec++; if (current_value !== 7'd0) begin n_err++; $display("FAIL reset_value: got %0d want 0", current_value); end
    n_vec++; if (param_flat !== '0) begin n_err++; $display("FAIL reset_flat: got nonzero want all 0"); end
    n_vec++; if (param_changed !== 1'b0) begin n_err++; $display("FAIL reset_changed: got %b want 0", param_changed); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_up;
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 3; i++) press_key(0, 10, 10);
    n_vec++; if (current_value !== 7'd3) begin n_err++; $display("FAIL up3_value: got %0d want 3", current_value); end
    n_vec++; if (pulse_cnt - p0 !== 3) begin n_err++; $display("FAIL up3_pulses: got %0d want 3", pulse_cnt - p0); end
    n_vec++; if (param_flat[20:14] !== 7'd0) begin n_err++; $display("FAIL up3_entry02: got %0d want 0", param_flat[20:14]); end
    n_vec++; if (param_flat[FLAT_W-1:7] !== '0) begin n_err++; $display("FAIL up3_others: got nonzero want 0"); end
  endtask

  task automatic test_saturation;
    int p0;
    press_key(2, 10, 10);
    n_vec++; if (param_sel !== 3'd1) begin n_err++; $display("FAIL sat_param: got %0d want 1", param_sel); end
    p0 = pulse_cnt;
    press_key(1, 10, 10);
    n_vec++; if (current_value !== 7'd0) begin n_err++; $display("FAIL down_floor: got %0d want 0", current_value); end
    n_vec++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("FAIL down_floor_pulse: got %0d want 0", pulse_cnt - p0); end
    p0 = pulse_cnt;
    for (int i = 0; i < 127; i++) press_key(0, 10, 10);
    n_vec++; if (current_value !== 7'd127) begin n_err++; $display("FAIL fill_value: got %0d want 127", current_value); end
    n_vec++; if (param_flat[13:7] !== 7'd127) begin n_err++; $display("FAIL fill_flat: got %0d want 127", param_flat[13:7]); end
    n_vec++; if (pulse_cnt - p0 !== 127) begin n_err++; $display("FAIL fill_pulses: got %0d want 127", pulse_cnt - p0); end
    p0 = pulse_cnt;
    press_key(0, 10, 10);
    n_vec++; if (current_value !== 7'd127) begin n_err++; $display("FAIL up_ceiling: got %0d want 127", current_value); end
    n_vec++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("FAIL up_ceiling_pulse: got %0d want 0", pulse_cnt - p0); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 5; i++) press_key(3, 10, 10);
    n_vec++; if (fx_sel !== 4'd5) begin n_err++; $display("FAIL fx5: got %0d want 5", fx_sel); end
    n_vec++; if (current_value !== 7'd0) begin n_err++; $display("FAIL fx5_value: got %0d want 0", current_value); end
    for (int i = 0; i < 11; i++) press_key(3, 10, 10);
    n_vec++; if (fx_sel !== 4'd0) begin n_err++; $display("FAIL fx_wrap: got %0d want 0", fx_sel); end
    n_vec++; if (param_sel !== 3'd1) begin n_err++; $display("FAIL fx_wrap_param: got %0d want 1", param_sel); end
    n_vec++; if (current_value !== 7'd127) begin n_err++; $display("FAIL fx_wrap_value: got %0d want 127", current_value); end
    for (int i = 0; i < 8; i++) press_key(2, 10, 10);
    n_vec++; if (param_sel !== 3'd1) begin n_err++; $display("FAIL param_wrap: got %0d want 1", param_sel); end
    n_vec++; if (current_value !== 7'd127) begin n_err++; $display("FAIL param_wrap_value: got %0d want 127", current_value); end
    n_vec++; if (param_flat[6:0] !== 7'd3) begin n_err++; $display("FAIL param_wrap_entry00: got %0d want 3", param_flat[6:0]); end
  endtask

  task automatic test_lock;
    int p0;
    SW[0] = 1'b1;
    repeat (4) @(negedge clk);
    p0 = pulse_cnt;
    press_key(1, 10, 10);
    press_key(0, 10, 10);
    n_vec++; if (current_value !== 7'd127) begin n_err++; $display("FAIL lock_value: got %0d want 127", current_value); end
    n_vec++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("FAIL lock_pulse: got %0d want 0", pulse_cnt - p0); end
    press_key(2, 10, 10);
    n_vec++; if (param_sel !== 3'd2) begin n_err++; $display("FAIL lock_nav: got %0d want 2", param_sel); end
    SW[0] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_glitch_and_priority;
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); KEY[0] = 1'b0;
      repeat (2) @(negedge clk); KEY[0] = 1'b1;
      repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    n_vec++; if (current_value !== 7'd0) begin n_err++; $display("FAIL glitch_value: got %0d want 0", current_value); end
    n_vec++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("FAIL glitch_pulse: got %0d want 0", pulse_cnt - p0); end
    @(negedge clk); KEY[0] = 1'b0; KEY[3] = 1'b0;
    repeat (10) @(negedge clk); KEY = 4'hF;
    repeat (10) @(negedge clk);
    n_vec++; if (fx_sel !== 4'd1) begin n_err++; $display("FAIL prio_fx: got %0d want 1", fx_sel); end
    n_vec++; if (param_sel !== 3'd2) begin n_err++; $display("FAIL prio_param: got %0d want 2", param_sel); end
    n_vec++; if (current_value !== 7'd0) begin n_err++; $display("FAIL prio_value: got %0d want 0", current_value); end
    n_vec++; if (param_flat[20:14] !== 7'd0) begin n_err++; $display("FAIL prio_entry02: got %0d want 0", param_flat[20:14]); end
    n_vec++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("FAIL prio_pulse: got %0d want 0", pulse_cnt - p0); end
  endtask

  task automatic test_hold_repeat;
    int p0;
    int exp_n;
    bit seen;
`ifdef PARAM_EDITOR_AUTOREPEAT_EN
    exp_n = 6;
`else
    exp_n = 1;
`endif
    p0 = pulse_cnt;
    seen = 1'b0;
    @(negedge clk); KEY[0] = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (current_value !== 7'd0) seen = 1'b1;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL hold_first_edit: got no change want change within 40 cycles"); end
    repeat (35) @(negedge clk);
    KEY[0] = 1'b1;
    repeat (20) @(negedge clk);
    n_vec++; if (current_value !== 7'(exp_n)) begin n_err++; $display("FAIL hold_value: got %0d want %0d", current_value, exp_n); end
    n_vec++; if (pulse_cnt - p0 !== exp_n) begin n_err++; $display("FAIL hold_pulses: got %0d want %0d", pulse_cnt - p0, exp_n); end
    n_vec++; if (param_flat[76:70] !== 7'(exp_n)) begin n_err++; $display("FAIL hold_flat: got %0d want %0d", param_flat[76:70], exp_n); end
  endtask

  task automatic test_reset_mid_hold;
    @(negedge clk); KEY[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (current_value !== 7'd0) begin n_err++; $display("FAIL rst_hold_value: got %0d want 0", current_value); end
    n_vec++; if (fx_sel !== 4'd0) begin n_err++; $display("FAIL rst_hold_fx: got %0d want 0", fx_sel); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++; if (current_value !== 7'd0) begin n_err++; $display("FAIL rst_hold_early: got %0d want 0", current_value); end
    repeat (10) @(negedge clk);
    n_vec++; if (current_value !== 7'd1) begin n_err++; $display("FAIL rst_hold_late: got %0d want 1", current_value); end
    KEY[0] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_up();
    test_saturation();
    test_wrap();
    test_lock();
    test_glitch_and_priority();
    test_hold_repeat();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
